ram_unpack128: RTL
==================

// Module: ram_unpack128
// PURPOSE
//  Reads 16 consecutive bytes from a byte-wide RAM and assembles them into a
//  128-bit block for the AES core's text input. This block is the read-side
//  counterpart of the AES result-to-RAM byte writer.
//  Byte k (k=0..15) is read from BASE_ADDR+k and placed in block_out[8k+7:8k].
//  This is the same byte order the writer uses, so a written block reads back
//  bit-identical.
// PARAMETERS
//  BASE_ADDR  8'd1  RAM address of byte 0 (bits [7:0]) of the block
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  rst_n        in   1    synchronous active-low reset
//  start        in   1    1-cycle pulse: begin fetching one block (honoured only in IDLE)
//  ram_rd_en    out  1    RAM read strobe, one byte per cycle
//  ram_addr     out  8    RAM read address
//  ram_rd_data  in   8    RAM read data, valid exactly 1 cycle after ram_rd_en
//  block_out    out  128  assembled block, stable while block_valid=1
//  block_valid  out  1    block_out is complete
//  block_ready  in   1    consumer accepts block_out when sampled with block_valid=1
//  busy         out  1    1 whenever state != IDLE
// BEHAVIOUR
//  Reset:
//  - rst_n=0 at a clock edge forces, on that edge: state=IDLE, ram_rd_en=0,
//    ram_addr=BASE_ADDR, block_out=0, block_valid=0, busy=0.
//  - Reset applied mid-operation aborts the fetch; partial data is discarded.
//  Outputs: all outputs are registered.
//  FSM states:
//  - IDLE: if start=1 -> READ, and on that edge set ram_rd_en=1, ram_addr=BASE_ADDR,
//    rd_cnt=0, block_out=0.
//  - READ: one read is issued per cycle. ram_addr increments by 1 each cycle
//    (8-bit, modulo-256 wrap, e.g. BASE_ADDR=8'hF8 reads F8..FF,00..07).
//    rd_cnt is 4 bits, 0..15. After the read with rd_cnt=15 is issued
//    -> DRAIN, with ram_rd_en=0 and ram_addr held.
//  - DRAIN: waits one cycle for the last byte to return, then -> HOLD with block_valid=1.
//  - HOLD: block_valid=1 and block_out held constant. When block_ready=1:
//    block_valid=0 on the next cycle -> IDLE. Waiting in HOLD is unbounded.
//  Data capture:
//  - A 1-cycle delayed copy of ram_rd_en (rd_en_d) and a 4-bit capture
//    counter wr_cnt gate capture.
//  - When rd_en_d=1: block_out[8*wr_cnt +: 8] <= ram_rd_data, then wr_cnt++.
//  - wr_cnt is cleared on entry to READ.
//  Timing (start sampled at edge 0):
//  - ram_rd_en is high in cycles 1..16, with addresses BASE..BASE+15.
//  - Data is captured in cycles 2..17.
//  - block_valid rises in cycle 18. Start-to-valid latency is 18 cycles.
//  - Minimum start-to-start period is 19 cycles (block_ready tied high).
//  Boundary rules:
//  - start outside IDLE (READ/DRAIN/HOLD) is ignored, including start in the
//    same cycle as the block_ready acceptance. start must be re-issued in IDLE.
//  - block_ready while block_valid=0 is ignored.
//  - ram_rd_data is don't-care when rd_en_d=0.
//  - A held-high start fetches a new block each time IDLE is re-entered.
// TESTING
//  T1 basic:
//   - RAM[1..16]=8'h00..8'h0F, pulse start, block_ready=1.
//   - Expect block_valid at cycle 18 and block_out=128'h0F0E0D0C0B0A09080706050403020100.
//   - Expect exactly 16 rd_en cycles at addresses 1..16.
//  T2 hold:
//   - block_ready=0 for 50 cycles after valid.
//   - Expect block_valid and block_out stable for all 50 cycles.
//   - Assert block_ready=1 for one cycle; expect valid=0 and busy=0 on the next cycle.
//  T3 start ignored:
//   - Pulse start at cycles 5 and 18 of a fetch.
//   - Expect no extra reads and a single block.
//   - A new start in IDLE fetches again.
//  T4 wrap:
//   - BASE_ADDR=8'hF8.
//   - Expect ram_addr F8..FF then 00..07.
//   - Expect the byte at F8 in bits [7:0] and the byte at 07 in bits [127:120].
//  T5 reset mid-fetch:
//   - rst_n=0 at cycle 9 for 1 cycle.
//   - Expect rd_en=0, block_out=0, busy=0 after that edge.
//   - A fresh start then yields the correct full block.
//  T6 loopback:
//   - AES writer stores 128'h3243F6A8885A308D313198A2E0370734 to RAM.
//   - This block reads it back; expect identical block_out.

Source files
------------

// File: rtl/ram_unpack128_if.sv
// ram_unpack128_if
//   Bundles the control, RAM-read and block-output signals of the 128-bit
//   RAM unpacker.
//   master : the unpacker itself (issues RAM reads, presents the block)
//   slave  : the environment (RAM model and block consumer)
//   Signals:
//     start        1-cycle request to fetch one block
//     ram_rd_en    RAM read strobe, one byte per cycle
//     ram_addr     RAM read address
//     ram_rd_data  RAM read data, valid one cycle after ram_rd_en
//     block_out    assembled 128-bit block
//     block_valid  block_out is complete
//     block_ready  consumer accepts block_out
//     busy         unpacker is not idle
interface ram_unpack128_if;
    logic         start;
    logic         ram_rd_en;
    logic [7:0]   ram_addr;
    logic [7:0]   ram_rd_data;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         busy;

    modport master (
        input  start,
        input  ram_rd_data,
        input  block_ready,
        output ram_rd_en,
        output ram_addr,
        output block_out,
        output block_valid,
        output busy
    );

    modport slave (
        output start,
        output ram_rd_data,
        output block_ready,
        input  ram_rd_en,
        input  ram_addr,
        input  block_out,
        input  block_valid,
        input  busy
    );
endinterface

// File: rtl/ram_unpack128.sv
// ram_unpack128
//   Reads 16 consecutive bytes from a byte-wide RAM starting at BASE_ADDR and
//   assembles them into a 128-bit block: byte k (from BASE_ADDR+k, modulo 256)
//   lands in block_out[8k+7:8k], matching the byte order of the result writer.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    ram_unpack128_if.master (start, RAM read port, block handshake, busy)
//   Parameters:
//     BASE_ADDR  RAM address of byte 0 of the block
module ram_unpack128 #(
    parameter logic [7:0] BASE_ADDR = 8'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_unpack128_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t       state_reg, state_next;
    logic         rd_en_reg, rd_en_next;
    logic [7:0]   addr_reg, addr_next;
    logic [3:0]   rd_cnt_reg, rd_cnt_next;
    logic         valid_reg, valid_next;
    logic         busy_reg;
    logic         rd_en_d_reg;
    logic [3:0]   wr_cnt_reg, wr_cnt_next;
    logic         clear_block;
    logic [7:0]   byte_reg [16];
    logic [127:0] block_flat;

    // Next-state and output decode
    always_comb begin
        state_next  = state_reg;
        rd_en_next  = rd_en_reg;
        addr_next   = addr_reg;
        rd_cnt_next = rd_cnt_reg;
        valid_next  = valid_reg;
        clear_block = 1'b0;
        wr_cnt_next = wr_cnt_reg;

        // Capture pointer advances with every returned byte
        if (rd_en_d_reg) begin
            wr_cnt_next = wr_cnt_reg + 4'd1;
        end

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next  = READ;
                    rd_en_next  = 1'b1;
                    addr_next   = BASE_ADDR;
                    rd_cnt_next = 4'd0;
                    wr_cnt_next = 4'd0;
                    clear_block = 1'b1;
                end
            end
            READ: begin
                if (rd_cnt_reg == 4'd15) begin
                    // Last read issued; address is held so the bus stays quiet
                    state_next = DRAIN;
                    rd_en_next = 1'b0;
                end else begin
                    addr_next   = addr_reg + 8'd1;
                    rd_cnt_next = rd_cnt_reg + 4'd1;
                end
            end
            DRAIN: begin
                // Final byte is captured on this edge
                state_next = HOLD;
                valid_next = 1'b1;
            end
            HOLD: begin
                if (bus.block_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                rd_en_next = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rd_en_reg   <= 1'b0;
            addr_reg    <= BASE_ADDR;
            rd_cnt_reg  <= 4'd0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            rd_en_d_reg <= 1'b0;
            wr_cnt_reg  <= 4'd0;
        end else begin
            state_reg   <= state_next;
            rd_en_reg   <= rd_en_next;
            addr_reg    <= addr_next;
            rd_cnt_reg  <= rd_cnt_next;
            valid_reg   <= valid_next;
            busy_reg    <= (state_next != IDLE);
            rd_en_d_reg <= rd_en_reg;
            wr_cnt_reg  <= wr_cnt_next;
        end
    end

    // One byte lane per block position; a lane loads only when the returning
    // byte belongs to it.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    byte_reg[gi] <= 8'h00;
                end else if (clear_block) begin
                    byte_reg[gi] <= 8'h00;
                end else if (rd_en_d_reg && (wr_cnt_reg == 4'(gi))) begin
                    byte_reg[gi] <= bus.ram_rd_data;
                end
            end
            assign block_flat[8*gi +: 8] = byte_reg[gi];
        end
    endgenerate

    assign bus.ram_rd_en   = rd_en_reg;
    assign bus.ram_addr    = addr_reg;
    assign bus.block_out   = block_flat;
    assign bus.block_valid = valid_reg;
    assign bus.busy        = busy_reg;

endmodule
